// File: rtl/uart_harness.sv
// UART register-access harness: a host engine serialises register read/write
// bursts to a device engine holding a 16x16 register stub, sharing one baud divisor.

module uart_harness_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        busy,
  output logic        done,
  output logic        tx
);
  logic [15:0] div_q;
  logic [15:0] clk_cnt;
  logic [3:0]  smp;
  logic [3:0]  bit_idx;
  logic [9:0]  shreg;
  logic        tick;

  assign tick = busy && (clk_cnt == div_q - 16'd1);
  assign tx   = shreg[0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      div_q   <= 16'd1;
      clk_cnt <= '0;
      smp     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          div_q   <= div;
          clk_cnt <= '0;
          smp     <= '0;
          bit_idx <= '0;
          shreg   <= {1'b1, data, 1'b0};
        end
      end else if (tick) begin
        clk_cnt <= '0;
        smp     <= smp + 4'd1;
        if (smp == 4'd15) begin
          if (bit_idx == 4'd9) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            shreg   <= {1'b1, shreg[9:1]};
          end
        end
      end else begin
        clk_cnt <= clk_cnt + 16'd1;
      end
    end
  end
endmodule

module uart_harness_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] div,
  input  logic        rx,
  output logic        valid,
  output logic [7:0]  data
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   state, state_d;
  logic [15:0] div_q;
  logic [15:0] clk_cnt;
  logic [3:0]  smp;
  logic [2:0]  bit_idx;
  logic        tick;
  logic        mid_start;
  logic        mid_bit;

  assign tick      = (state != RX_IDLE) && (clk_cnt == div_q - 16'd1);
  assign mid_start = tick && (smp == 4'd7);
  assign mid_bit   = tick && (smp == 4'd15);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      RX_IDLE:  if (!rx) state_d = RX_START;
      RX_START: if (mid_start) state_d = rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (mid_bit && bit_idx == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (mid_bit) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Both lines are driven by flops in this clock domain, so no synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RX_IDLE;
      div_q   <= 16'd1;
      clk_cnt <= '0;
      smp     <= '0;
      bit_idx <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      state <= state_d;
      valid <= 1'b0;
      if (state == RX_IDLE) begin
        div_q   <= div;
        clk_cnt <= '0;
        smp     <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        clk_cnt <= '0;
        smp     <= (state == RX_START && mid_start) ? 4'd0 : smp + 4'd1;
        if (state == RX_DATA && mid_bit) begin
          data    <= {rx, data[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
        if (state == RX_STOP && mid_bit && rx) valid <= 1'b1;
      end else begin
        clk_cnt <= clk_cnt + 16'd1;
      end
    end
  end
endmodule

module uart_harness #(
  parameter logic [3:0]  BASEADDR     = 4'h2,
  parameter logic [15:0] DEFAULT_BAUD = 16'd68
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_config,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wbuf_we,
  input  logic [3:0]  wbuf_idx,
  input  logic [15:0] wbuf_data,
  input  logic [3:0]  rbuf_idx,
  output logic [15:0] rbuf_data,
  output logic        cmd_done,
  output logic        uart_line,
  output logic        uart_resp
);
  typedef enum logic [2:0] {H_IDLE, H_HDR, H_DATA, H_RECV, H_DONE} host_state_t;
  typedef enum logic [1:0] {D_IDLE, D_HDR, D_WDATA, D_RDATA} dev_state_t;

  logic [15:0] div_eff;
  assign div_eff = (baud_config == 16'd0) ? DEFAULT_BAUD : baud_config;

  logic [15:0] wbuf [16];
  logic [15:0] rbuf [16];
  logic [15:0] regs [16];

  // ---------------- host engine ----------------
  host_state_t h_state, h_state_d;
  logic        h_write;
  logic [15:0] h_addr;
  logic [3:0]  h_len;
  logic [5:0]  h_cnt;
  logic [5:0]  h_total;
  logic [7:0]  h_hi;
  logic        accept;
  logic        htx_start, htx_busy, htx_done;
  logic [7:0]  htx_data;
  logic        hrx_valid;
  logic [7:0]  hrx_data;
  logic        hrx_byte;
  logic [15:0] h_word;

  assign h_total   = {1'b0, h_len, 1'b0} + 6'd2;
  assign cmd_ready = (h_state == H_IDLE) || (h_state == H_DONE);
  assign cmd_done  = (h_state == H_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign hrx_byte  = (h_state == H_RECV) && hrx_valid;
  assign h_word    = wbuf[h_cnt[4:1]];
  assign rbuf_data = rbuf[rbuf_idx];

  always_comb begin
    h_state_d = h_state;
    htx_start = 1'b0;
    htx_data  = '0;
    case (h_state)
      H_IDLE, H_DONE: begin
        if (accept)                 h_state_d = H_HDR;
        else if (h_state == H_DONE) h_state_d = H_IDLE;
      end
      H_HDR: begin
        if (!htx_busy) begin
          if (h_cnt < 6'd3) begin
            htx_start = 1'b1;
            case (h_cnt[1:0])
              2'd0:    htx_data = {h_write, 3'b000, h_len};
              2'd1:    htx_data = h_addr[15:8];
              default: htx_data = h_addr[7:0];
            endcase
          end else begin
            h_state_d = h_write ? H_DATA : H_RECV;
          end
        end
      end
      H_DATA: begin
        if (!htx_busy) begin
          if (h_cnt < h_total) begin
            htx_start = 1'b1;
            htx_data  = h_cnt[0] ? h_word[7:0] : h_word[15:8];
          end else begin
            h_state_d = H_DONE;
          end
        end
      end
      H_RECV:  if (hrx_byte && h_cnt == h_total - 6'd1) h_state_d = H_DONE;
      default: h_state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state <= H_IDLE;
      h_write <= 1'b0;
      h_addr  <= '0;
      h_len   <= '0;
      h_cnt   <= '0;
      h_hi    <= '0;
    end else begin
      h_state <= h_state_d;
      if (accept) begin
        h_write <= cmd_write;
        h_addr  <= cmd_addr;
        h_len   <= cmd_len;
      end
      if (h_state_d != h_state)       h_cnt <= '0;
      else if (htx_start || hrx_byte) h_cnt <= h_cnt + 6'd1;
      if (hrx_byte && !h_cnt[0])      h_hi  <= hrx_data;
    end
  end

  // NOTE: the buffers and register stub are reset with a loop because their
  // contents are architecturally visible as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
    end else if (wbuf_we) begin
      wbuf[wbuf_idx] <= wbuf_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rbuf[i] <= '0;
    end else if (hrx_byte && h_cnt[0]) begin
      rbuf[h_cnt[4:1]] <= {h_hi, hrx_data};
    end
  end

  uart_harness_tx u_host_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div_eff),
    .start (htx_start),
    .data  (htx_data),
    .busy  (htx_busy),
    .done  (htx_done),
    .tx    (uart_line)
  );

  uart_harness_rx u_host_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div_eff),
    .rx    (uart_resp),
    .valid (hrx_valid),
    .data  (hrx_data)
  );

  // ---------------- device engine ----------------
  dev_state_t  d_state, d_state_d;
  logic        d_write;
  logic [3:0]  d_len;
  logic [3:0]  d_region;
  logic [3:0]  d_base;
  logic [5:0]  d_cnt;
  logic [5:0]  d_total;
  logic [7:0]  d_hi;
  logic        d_match;
  logic [3:0]  d_off;
  logic [15:0] d_word;
  logic        drx_valid;
  logic [7:0]  drx_data;
  logic        dtx_start, dtx_busy, dtx_done;
  logic [7:0]  dtx_data;
  logic        reg_we;

  assign d_total = {1'b0, d_len, 1'b0} + 6'd2;
  assign d_match = (d_region == BASEADDR);
  assign d_off   = d_base + d_cnt[4:1];
  // Out-of-region reads return zeros so the host always gets its full burst.
  assign d_word  = d_match ? regs[d_off] : 16'h0000;
  assign reg_we  = (d_state == D_WDATA) && drx_valid && d_cnt[0] && d_match;

  always_comb begin
    d_state_d = d_state;
    dtx_start = 1'b0;
    dtx_data  = '0;
    case (d_state)
      D_IDLE:  if (drx_valid) d_state_d = D_HDR;
      D_HDR:   if (drx_valid && d_cnt == 6'd2) d_state_d = d_write ? D_WDATA : D_RDATA;
      D_WDATA: if (drx_valid && d_cnt == d_total - 6'd1) d_state_d = D_IDLE;
      D_RDATA: begin
        if (!dtx_busy) begin
          if (d_cnt < d_total) begin
            dtx_start = 1'b1;
            dtx_data  = d_cnt[0] ? d_word[7:0] : d_word[15:8];
          end else begin
            d_state_d = D_IDLE;
          end
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state  <= D_IDLE;
      d_write  <= 1'b0;
      d_len    <= '0;
      d_region <= '0;
      d_base   <= '0;
      d_cnt    <= '0;
      d_hi     <= '0;
    end else begin
      d_state <= d_state_d;
      case (d_state)
        D_IDLE: if (drx_valid) begin
          d_write <= drx_data[7];
          d_len   <= drx_data[3:0];
          d_cnt   <= 6'd1;
        end
        D_HDR: if (drx_valid) begin
          // Offset bits [11:4] are not decoded by the 16-entry stub.
          if (d_cnt == 6'd1) d_region <= drx_data[7:4];
          else               d_base   <= drx_data[3:0];
          d_cnt <= (d_cnt == 6'd2) ? 6'd0 : d_cnt + 6'd1;
        end
        D_WDATA: if (drx_valid) begin
          if (!d_cnt[0]) d_hi <= drx_data;
          d_cnt <= d_cnt + 6'd1;
        end
        D_RDATA: if (dtx_start) d_cnt <= d_cnt + 6'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[d_off] <= {d_hi, drx_data};
    end
  end

  uart_harness_rx u_dev_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div_eff),
    .rx    (uart_line),
    .valid (drx_valid),
    .data  (drx_data)
  );

  uart_harness_tx u_dev_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div_eff),
    .start (dtx_start),
    .data  (dtx_data),
    .busy  (dtx_busy),
    .done  (dtx_done),
    .tx    (uart_resp)
  );

  logic unused_done;
  assign unused_done = htx_done ^ dtx_done;
endmodule

// File: tb/tb_uart_harness.sv
// Self-checking bench for uart_harness: table-driven single transfers, burst,
// baud changes, out-of-region access and mid-command reset, with a readback scoreboard.

module tb_uart_harness;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_config = 16'd1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wbuf_we = 1'b0;
  logic [3:0]  wbuf_idx = '0;
  logic [15:0] wbuf_data = '0;
  logic [3:0]  rbuf_idx = '0;
  logic [15:0] rbuf_data;
  logic        cmd_done;
  logic        uart_line;
  logic        uart_resp;

  uart_harness dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_config (baud_config),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wbuf_we     (wbuf_we),
    .wbuf_idx    (wbuf_idx),
    .wbuf_data   (wbuf_data),
    .rbuf_idx    (rbuf_idx),
    .rbuf_data   (rbuf_data),
    .cmd_done    (cmd_done),
    .uart_line   (uart_line),
    .uart_resp   (uart_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] baud;
    logic [15:0] data;  // write data, or expected read data
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   done_exp = 0;

  always @(posedge clk) if (cmd_done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic load_wbuf(input logic [3:0] idx, input logic [15:0] val);
    @(negedge clk);
    wbuf_we   = 1'b1;
    wbuf_idx  = idx;
    wbuf_data = val;
    @(negedge clk);
    wbuf_we   = 1'b0;
  endtask

  task automatic issue(input string name, input logic wr, input logic [15:0] addr,
                       input logic [3:0] len, input logic [15:0] baud);
    @(negedge clk);
    baud_config = baud;
    cmd_write   = wr;
    cmd_addr    = addr;
    cmd_len     = len;
    cmd_valid   = 1'b1;
    @(negedge clk);
    cmd_valid   = 1'b0;
    check({name, "_ready_fall"}, cmd_ready, 0);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (cmd_done !== 1'b1 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_done"}, cmd_done, 1);
    check({name, "_ready_at_done"}, cmd_ready, 1);
    @(negedge clk);
    check({name, "_done_pulse"}, cmd_done, 0);
  endtask

  task automatic drain_sb(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rbuf_idx = e.idx;
      #1;
      check($sformatf("%s_rbuf%0d", name, e.idx), rbuf_data, e.val);
    end
  endtask

  task automatic run_cmd(input string name, input logic wr, input logic [15:0] addr,
                         input logic [3:0] len, input logic [15:0] baud);
    issue(name, wr, addr, len, baud);
    wait_done(name);
    done_exp++;
    check({name, "_donecnt"}, done_cnt, done_exp);
    drain_sb(name);
  endtask

  // Counts clocks that the first start bit of a command stays low.
  task automatic measure_start(input string name, input int exp);
    int c;
    int w;
    c = 0;
    w = 0;
    while (uart_line && c < 200) begin
      @(negedge clk);
      c++;
    end
    while (!uart_line && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check(name, w, exp);
  endtask

  task automatic check_idle_after_reset(input string name);
    rbuf_idx = 4'd0;
    #1;
    check({name, "_line"}, uart_line, 1);
    check({name, "_resp"}, uart_resp, 1);
    check({name, "_ready"}, cmd_ready, 1);
    check({name, "_done"}, cmd_done, 0);
    check({name, "_rbuf0"}, rbuf_data, 0);
  endtask

  initial begin
    vec_t        vecs[12];
    logic [15:0] bw[16];

    vecs[0]  = '{1'b1, 16'h2008, 16'd1, 16'h8888};
    vecs[1]  = '{1'b0, 16'h2008, 16'd1, 16'h8888};
    vecs[2]  = '{1'b1, 16'h2008, 16'd2, 16'hc3a5};
    vecs[3]  = '{1'b0, 16'h2008, 16'd2, 16'hc3a5};
    vecs[4]  = '{1'b1, 16'h3008, 16'd1, 16'h1234};
    vecs[5]  = '{1'b0, 16'h3008, 16'd1, 16'h0000};
    vecs[6]  = '{1'b0, 16'h2008, 16'd2, 16'hc3a5};
    vecs[7]  = '{1'b1, 16'h2ff3, 16'd2, 16'hbeef};
    vecs[8]  = '{1'b0, 16'h2003, 16'd1, 16'hbeef};
    vecs[9]  = '{1'b1, 16'h2008, 16'd1, 16'h8888};
    vecs[10] = '{1'b0, 16'h2008, 16'd2, 16'h8888};
    vecs[11] = '{1'b0, 16'h2013, 16'd1, 16'hbeef};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", cmd_done, 0);
    check("rst_line", uart_line, 1);
    check("rst_resp", uart_resp, 1);
    for (int i = 0; i < 16; i++) begin
      rbuf_idx = 4'(i);
      #1;
      check($sformatf("rst_rbuf%0d", i), rbuf_data, 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-word table, alternating baud rates
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) load_wbuf(4'd0, vecs[i].data);
      else            sb.push_back('{4'd0, vecs[i].data});
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, 4'd0, vecs[i].baud);
    end

    // Bit period at divisor 2 (byte0 = 0x81 so the start bit is isolated)
    issue("per2", 1'b1, 16'h3000, 4'd1, 16'd2);
    measure_start("per2_bit_clocks", 32);
    wait_done("per2");
    done_exp++;
    check("per2_donecnt", done_cnt, done_exp);

    // Wrapping 16-word burst
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = 4'(i + 1);
      bw[i] = (i == 15) ? 16'habcd : {n, n, n, n};
      load_wbuf(4'(i), bw[i]);
    end
    run_cmd("bwr", 1'b1, 16'h2001, 4'd15, 16'd2);
    for (int i = 0; i < 16; i++) sb.push_back('{4'(i), bw[i]});
    run_cmd("brd", 1'b0, 16'h2001, 4'd15, 16'd2);
    sb.push_back('{4'd0, 16'habcd});
    run_cmd("rd_reg0", 1'b0, 16'h2000, 4'd0, 16'd1);
    rbuf_idx = 4'd1;
    #1;
    check("rbuf1_kept", rbuf_data, bw[1]);

    // Reset in the middle of a burst write's data phase
    issue("abort", 1'b1, 16'h2001, 4'd15, 16'd1);
    repeat (1500) @(negedge clk);
    rst_n = 1'b0;
    check_idle_after_reset("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_done", done_cnt, done_exp);

    sb.push_back('{4'd0, 16'h0000});
    sb.push_back('{4'd1, 16'h0000});
    run_cmd("post_abort_rd", 1'b0, 16'h2001, 4'd1, 16'd1);

    // cmd_valid while busy must be ignored
    load_wbuf(4'd0, 16'h7777);
    issue("busy_wr", 1'b1, 16'h2005, 4'd0, 16'd2);
    repeat (200) @(negedge clk);
    cmd_write = 1'b1;
    cmd_addr  = 16'h2006;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("busy_ready_low", cmd_ready, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("busy_wr");
    done_exp++;
    repeat (20) @(negedge clk);
    check("busy_donecnt", done_cnt, done_exp);
    sb.push_back('{4'd0, 16'h7777});
    run_cmd("rd_2005", 1'b0, 16'h2005, 4'd0, 16'd1);
    sb.push_back('{4'd0, 16'h0000});
    run_cmd("rd_2006", 1'b0, 16'h2006, 4'd0, 16'd2);

    // baud_config = 0 selects the default divisor; abort during the header
    issue("dflt", 1'b1, 16'h3000, 4'd1, 16'd0);
    measure_start("dflt_bit_clocks", 1088);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    check_idle_after_reset("dflt_abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("dflt_no_done", done_cnt, done_exp);

    sb.push_back('{4'd0, 16'h0000});
    run_cmd("final_rd", 1'b0, 16'h2005, 4'd0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
